// File: rtl/valid_position_tracker.sv
// valid_position_tracker
// Receives the delayed pixel-valid stream at the end of the descriptor pipeline.
// Each valid pixel gets a raster (x,y) position, an interior flag (its patch
// fits inside the image), end-of-line / end-of-frame marks and a frame count.
// Outputs are registered and describe the counters before they advance.
//
//   state | meaning
//   IDLE  | waiting for the first pixel (0,0) of a frame
//   RUN   | inside a frame, until pixel (W-1,H-1) is taken
module valid_position_tracker #(
  parameter int W      = 640,
  parameter int H      = 480,
  parameter int BX     = 10,
  parameter int BY     = 9,
  parameter int BORDER = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          val_in,
  output logic          val_out,
  output logic [BX-1:0] x_out,
  output logic [BY-1:0] y_out,
  output logic          inner_out,
  output logic          eol_out,
  output logic          eof_out,
  output logic          busy_out,
  output logic [7:0]    frm_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [BX-1:0] X_LAST = BX'(W - 1);
  localparam logic [BY-1:0] Y_LAST = BY'(H - 1);
  localparam logic [BX-1:0] X_LO   = BX'(BORDER);
  localparam logic [BX-1:0] X_HI   = BX'(W - 1 - BORDER);
  localparam logic [BY-1:0] Y_LO   = BY'(BORDER);
  localparam logic [BY-1:0] Y_HI   = BY'(H - 1 - BORDER);

  state_e        state_q, state_d;
  logic [BX-1:0] x_q, x_d;
  logic [BY-1:0] y_q, y_d;
  logic [7:0]    frm_q, frm_d;
  logic          val_q, val_d;
  logic [BX-1:0] xo_q, xo_d;
  logic [BY-1:0] yo_q, yo_d;
  logic          inner_q, inner_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;

  logic take;
  logic last_x;
  logic last_y;
  logic inner_now;

  // clr wins over val_in, so a pixel arriving with clr is never counted
  assign take      = val_in && !clr;
  assign last_x    = (x_q == X_LAST);
  assign last_y    = (y_q == Y_LAST);
  assign inner_now = (x_q >= X_LO) && (x_q <= X_HI) && (y_q >= Y_LO) && (y_q <= Y_HI);

  // next-state: frame FSM, raster counters, frame counter and output flags
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    frm_d   = frm_q;
    val_d   = take;
    xo_d    = xo_q;
    yo_d    = yo_q;
    inner_d = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;

    if (clr) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
    end else if (val_in) begin
      xo_d    = x_q;
      yo_d    = y_q;
      inner_d = inner_now;
      eol_d   = last_x;
      eof_d   = last_x && last_y;

      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase

      if (last_x) begin
        x_d = '0;
        if (last_y) begin
          y_d     = '0;
          frm_d   = frm_q + 8'd1;
          state_d = IDLE;
        end else begin
          y_d = y_q + BY'(1);
        end
      end else begin
        x_d = x_q + BX'(1);
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      frm_q   <= '0;
      val_q   <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
      inner_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frm_q   <= frm_d;
      val_q   <= val_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      inner_q <= inner_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  assign val_out   = val_q;
  assign x_out     = xo_q;
  assign y_out     = yo_q;
  assign inner_out = inner_q;
  assign eol_out   = eol_q;
  assign eof_out   = eof_q;
  assign busy_out  = (state_q == RUN);
  assign frm_cnt   = frm_q;

endmodule

// File: tb/tb_valid_position_tracker.sv
// Testbench for valid_position_tracker. Uses a reduced image geometry so that
// several complete frames fit in a short run; the reference model below works
// directly from pixel coordinates and frame rules.
module tb_valid_position_tracker;

  localparam int W  = 64;
  localparam int H  = 48;
  localparam int BX = 7;
  localparam int BY = 6;
  localparam int B  = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          val_in;
  logic          val_out;
  logic [BX-1:0] x_out;
  logic [BY-1:0] y_out;
  logic          inner_out;
  logic          eol_out;
  logic          eof_out;
  logic          busy_out;
  logic [7:0]    frm_cnt;

  valid_position_tracker #(.W(W), .H(H), .BX(BX), .BY(BY), .BORDER(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .val_in    (val_in),
    .val_out   (val_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .inner_out (inner_out),
    .eol_out   (eol_out),
    .eof_out   (eof_out),
    .busy_out  (busy_out),
    .frm_cnt   (frm_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: next pixel position, frame count, in-frame flag
  int mx = 0, my = 0, mfrm = 0;
  bit mrun = 0;
  // expected registered outputs
  bit ev = 0, ein = 0, eeol = 0, eeof = 0;
  int ex = 0, ey = 0;
  bit frame_start = 1;
  int n_eol = 0, n_eof = 0;

  // interior probe points (x, y, expected inner)
  int px[5] = '{15, 14, 48, 49, 10};
  int py[5] = '{15, 20, 15, 15, 33};
  bit pi[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit c);
    logic [25:0] expv;
    rst_n  = r;
    val_in = v;
    clr    = c;
    if (!r) begin
      mx = 0; my = 0; mfrm = 0; mrun = 0;
      ev = 0; ex = 0; ey = 0; ein = 0; eeol = 0; eeof = 0;
      frame_start = 1;
    end else if (c) begin
      mx = 0; my = 0; mrun = 0;
      ev = 0; ein = 0; eeol = 0; eeof = 0;
      frame_start = 1;
    end else if (v) begin
      ev   = 1;
      ex   = mx;
      ey   = my;
      ein  = (mx >= B) && (mx <= W - 1 - B) && (my >= B) && (my <= H - 1 - B);
      eeol = (mx == W - 1);
      eeof = eeol && (my == H - 1);
      if (eeof) begin
        mfrm = (mfrm + 1) % 256;
        mrun = 0;
        mx = 0; my = 0;
      end else begin
        mrun = 1;
        if (eeol) begin mx = 0; my = my + 1; end
        else mx = mx + 1;
      end
    end else begin
      ev = 0; ein = 0; eeol = 0; eeof = 0;
    end
    @(negedge clk);
    expv = {ev, BX'(ex), BY'(ey), ein, eeol, eeof, mrun, 8'(mfrm)};
    check("outs", {38'd0, val_out, x_out, y_out, inner_out, eol_out, eof_out, busy_out, frm_cnt},
          {38'd0, expv});
    if (eol_out) n_eol++;
    if (eof_out) begin
      n_eof++;
      check("eof_pos", {x_out, y_out}, {BX'(W - 1), BY'(H - 1)});
    end
    for (int i = 0; i < 5; i++)
      if (ev && ex == px[i] && ey == py[i])
        check($sformatf("inner_%0d_%0d", px[i], py[i]), inner_out, pi[i]);
    if (ev && frame_start) begin
      check("frame_start", {val_out, x_out, y_out}, {1'b1, BX'(0), BY'(0)});
      frame_start = 0;
    end
    if (r && !c && v && eeof) frame_start = 1;
  endtask

  initial begin
    int k;
    int target;
    rst_n = 1'b0; clr = 1'b0; val_in = 1'b0;
    @(negedge clk);

    // reset held with val_in high
    repeat (3) step(0, 1, 0);
    check("rst_val", val_out, 0);
    check("rst_busy", busy_out, 0);

    // continuous full frame from reset release
    n_eol = 0; n_eof = 0;
    step(1, 1, 0);
    check("first_px", {val_out, x_out, y_out}, {1'b1, BX'(0), BY'(0)});
    repeat (W * H - 1) step(1, 1, 0);
    check("busy_after_eof", busy_out, 0);
    repeat (3) step(1, 0, 0);
    check("eol_count", n_eol, H);
    check("eof_count", n_eof, 1);
    check("frm_after_1", frm_cnt, 1);

    // gappy frame, ~50% duty
    target = mfrm + 1; k = 0;
    while (mfrm != target && k < 8 * W * H) begin
      step(1, 1'($urandom_range(0, 1)), 0);
      k++;
    end
    check("gappy_done", k < 8 * W * H, 1);
    check("frm_after_2", frm_cnt, 2);

    // clr mid-frame at (30,10) with val_in high
    k = 0;
    while (!(mx == 30 && my == 10) && k < W * H) begin step(1, 1, 0); k++; end
    step(1, 1, 1);
    check("clr_val", val_out, 0);
    check("clr_busy", busy_out, 0);
    check("clr_frm", frm_cnt, 2);
    repeat (2) step(1, 0, 0);
    check("clr_idle_busy", busy_out, 0);
    step(1, 1, 0);
    check("after_clr", {val_out, x_out, y_out, busy_out}, {1'b1, BX'(0), BY'(0), 1'b1});
    k = 0;
    while (mfrm != 3 && k < 2 * W * H) begin step(1, 1, 0); k++; end
    check("frm_after_3", frm_cnt, 3);

    // back-to-back frames
    n_eol = 0; n_eof = 0;
    repeat (2 * W * H) step(1, 1, 0);
    check("b2b_eof_count", n_eof, 2);
    check("b2b_eol_count", n_eol, 2 * H);
    check("b2b_frm", frm_cnt, 5);

    // reset mid-frame, then random mix with occasional clr / reset
    repeat (500) step(1, 1, 0);
    step(0, 1'($urandom_range(0, 1)), 0);
    check("midrst_frm", frm_cnt, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    repeat (4000) begin
      step(($urandom_range(0, 255) != 0), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
